// File: rtl/rob_ctrl_pkg.sv
// rtl/rob_ctrl_pkg.sv - shared sizes, opcode constant and ROB row layout
package rob_ctrl_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int PREG_W    = 6;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic              v;
    logic              is_store;
    logic [PREG_W-1:0] phy_reg;
    logic [PREG_W-1:0] old_phy;
    logic              comp;
  } rob_row;

  function automatic logic is_store_op(input logic [6:0] op);
    return op == OP_STORE;
  endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// rtl/rob_ctrl_if.sv - dispatch, completion and retire signals of the ROB sequencer
interface rob_ctrl_if;
  import rob_ctrl_pkg::*;

  logic              disp_valid_1;
  logic              disp_valid_2;
  logic [PREG_W-1:0] rob_p_1;
  logic [PREG_W-1:0] rob_p_2;
  logic [PREG_W-1:0] o_rob_p_1;
  logic [PREG_W-1:0] o_rob_p_2;
  logic [6:0]        rob_op_1;
  logic [6:0]        rob_op_2;
  logic              disp_ready;
  logic [TAG_W-1:0]  disp_tag_1;
  logic [TAG_W-1:0]  disp_tag_2;

  logic              cmp_valid_1;
  logic              cmp_valid_2;
  logic              cmp_valid_3;
  logic [TAG_W-1:0]  cmp_tag_1;
  logic [TAG_W-1:0]  cmp_tag_2;
  logic [TAG_W-1:0]  cmp_tag_3;

  logic              rt_valid_1;
  logic              rt_valid_2;
  logic              rt_flag_1;
  logic              rt_flag_2;
  logic [PREG_W-1:0] fp_i_1;
  logic [PREG_W-1:0] fp_i_2;
  logic [TAG_W:0]    rob_count;
  logic              rob_empty;

  modport master (
    output disp_valid_1, disp_valid_2, rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2,
           rob_op_1, rob_op_2, cmp_valid_1, cmp_valid_2, cmp_valid_3,
           cmp_tag_1, cmp_tag_2, cmp_tag_3,
    input  disp_ready, disp_tag_1, disp_tag_2, rt_valid_1, rt_valid_2,
           rt_flag_1, rt_flag_2, fp_i_1, fp_i_2, rob_count, rob_empty
  );

  modport slave (
    input  disp_valid_1, disp_valid_2, rob_p_1, rob_p_2, o_rob_p_1, o_rob_p_2,
           rob_op_1, rob_op_2, cmp_valid_1, cmp_valid_2, cmp_valid_3,
           cmp_tag_1, cmp_tag_2, cmp_tag_3,
    output disp_ready, disp_tag_1, disp_tag_2, rt_valid_1, rt_valid_2,
           rt_flag_1, rt_flag_2, fp_i_1, fp_i_2, rob_count, rob_empty
  );

endinterface

// File: rtl/rob_ctrl.sv
// rtl/rob_ctrl.sv - 16-entry circular ROB: dual dispatch, triple completion, dual in-order retire
module rob_ctrl
  import rob_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  rob_ctrl_if.slave   rob
);

  rob_row           rows_q [ROB_DEPTH];
  rob_row           rows_d [ROB_DEPTH];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic              rt_valid_1_q, rt_valid_1_d;
  logic              rt_valid_2_q, rt_valid_2_d;
  logic              rt_flag_1_q, rt_flag_1_d;
  logic              rt_flag_2_q, rt_flag_2_d;
  logic [PREG_W-1:0] fp_i_1_q, fp_i_1_d;
  logic [PREG_W-1:0] fp_i_2_q, fp_i_2_d;

  logic             disp_ready;
  logic [TAG_W-1:0] tag_2;
  logic [TAG_W-1:0] head_p1;
  logic             alloc_1, alloc_2;
  logic             ret_1, ret_2;
  logic [TAG_W:0]   n_alloc, n_ret;

  // Space check uses the pre-edge count only, so same-edge retires never admit a dispatch.
  assign disp_ready = count_q <= (TAG_W+1)'(ROB_DEPTH - 2);
  assign tag_2      = tail_q + TAG_W'(rob.disp_valid_1);
  assign head_p1    = head_q + TAG_W'(1);
  assign alloc_1    = disp_ready && rob.disp_valid_1;
  assign alloc_2    = disp_ready && rob.disp_valid_2;
  assign ret_1      = rows_q[head_q].v && rows_q[head_q].comp;
  assign ret_2      = ret_1 && rows_q[head_p1].v && rows_q[head_p1].comp;
  assign n_alloc    = (TAG_W+1)'(alloc_1) + (TAG_W+1)'(alloc_2);
  assign n_ret      = (TAG_W+1)'(ret_1) + (TAG_W+1)'(ret_2);

  always_comb begin
    rows_d = rows_q;

    // Completions look at the pre-edge valid bit, which also drops tags allocated this edge.
    if (rob.cmp_valid_1 && rows_q[rob.cmp_tag_1].v) rows_d[rob.cmp_tag_1].comp = 1'b1;
    if (rob.cmp_valid_2 && rows_q[rob.cmp_tag_2].v) rows_d[rob.cmp_tag_2].comp = 1'b1;
    if (rob.cmp_valid_3 && rows_q[rob.cmp_tag_3].v) rows_d[rob.cmp_tag_3].comp = 1'b1;

    if (ret_1) begin
      rows_d[head_q].v    = 1'b0;
      rows_d[head_q].comp = 1'b0;
    end
    if (ret_2) begin
      rows_d[head_p1].v    = 1'b0;
      rows_d[head_p1].comp = 1'b0;
    end

    // Allocated slots are always free pre-edge, so they never collide with a retiring head.
    if (alloc_1) begin
      rows_d[tail_q] = '{v: 1'b1, is_store: is_store_op(rob.rob_op_1),
                         phy_reg: rob.rob_p_1, old_phy: rob.o_rob_p_1, comp: 1'b0};
    end
    if (alloc_2) begin
      rows_d[tag_2] = '{v: 1'b1, is_store: is_store_op(rob.rob_op_2),
                        phy_reg: rob.rob_p_2, old_phy: rob.o_rob_p_2, comp: 1'b0};
    end
  end

  always_comb begin
    tail_d  = tail_q + n_alloc[TAG_W-1:0];
    head_d  = head_q + n_ret[TAG_W-1:0];
    count_d = count_q + n_alloc - n_ret;

    rt_valid_1_d = ret_1;
    rt_valid_2_d = ret_2;
    rt_flag_1_d  = ret_1 && !rows_q[head_q].is_store;
    rt_flag_2_d  = ret_2 && !rows_q[head_p1].is_store;
    fp_i_1_d     = ret_1 ? rows_q[head_q].old_phy  : '0;
    fp_i_2_d     = ret_2 ? rows_q[head_p1].old_phy : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rows_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      rt_valid_1_q <= 1'b0;
      rt_valid_2_q <= 1'b0;
      rt_flag_1_q  <= 1'b0;
      rt_flag_2_q  <= 1'b0;
      fp_i_1_q     <= '0;
      fp_i_2_q     <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) rows_q[i] <= rows_d[i];
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      rt_valid_1_q <= rt_valid_1_d;
      rt_valid_2_q <= rt_valid_2_d;
      rt_flag_1_q  <= rt_flag_1_d;
      rt_flag_2_q  <= rt_flag_2_d;
      fp_i_1_q     <= fp_i_1_d;
      fp_i_2_q     <= fp_i_2_d;
    end
  end

  assign rob.disp_ready = disp_ready;
  assign rob.disp_tag_1 = tail_q;
  assign rob.disp_tag_2 = tag_2;
  assign rob.rt_valid_1 = rt_valid_1_q;
  assign rob.rt_valid_2 = rt_valid_2_q;
  assign rob.rt_flag_1  = rt_flag_1_q;
  assign rob.rt_flag_2  = rt_flag_2_q;
  assign rob.fp_i_1     = fp_i_1_q;
  assign rob.fp_i_2     = fp_i_2_q;
  assign rob.rob_count  = count_q;
  assign rob.rob_empty  = count_q == '0;

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- In-order sequencer for the 16-entry circular Re-Order Buffer used by the complete/retire stage.
- Dispatch allocates up to 2 entries per cycle at the tail and receives the ROB tags. Up to 3 functional units mark entries complete by tag.
- Up to 2 completed entries retire per cycle from the head, strictly in order. Retiring returns the old physical register to the free list.

Parameters:
- ROB_DEPTH, 16, number of ROB entries (power of two).
- TAG_W, 4, log2(ROB_DEPTH).
- PREG_W, 6, physical register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- disp_valid_1  in  1  allocate entry for dispatch slot 1.
- disp_valid_2  in  1  allocate entry for dispatch slot 2.
- rob_p_1, rob_p_2  in  PREG_W  new destination physical reg per slot.
- o_rob_p_1, o_rob_p_2  in  PREG_W  previous (old) physical reg per slot.
- rob_op_1, rob_op_2  in  7  opcode per slot; 7'b0100011 = store.
- disp_ready  out  1  free entries >= 2 (combinational from count).
- disp_tag_1, disp_tag_2  out  TAG_W  tags assigned this cycle (combinational from tail).
- cmp_valid_1..3  in  1  FU completion strobes.
- cmp_tag_1..3  in  TAG_W  ROB tag being completed.
- rt_valid_1, rt_valid_2  out  1  entry retired this cycle (registered).
- rt_flag_1, rt_flag_2  out  1  retired entry frees a register (non-store).
- fp_i_1, fp_i_2  out  PREG_W  old physical reg to free.
- rob_count  out  TAG_W+1  occupied entries, 0..16.
- rob_empty  out  1  rob_count == 0.

Behaviour:
- Reset (async, any time, including mid-operation):
  - head = tail = 0, count = 0.
  - All valid and comp bits = 0.
  - rt_valid_*, rt_flag_*, fp_i_* = 0.
  - rob_empty = 1, disp_ready = 1.
- Entry fields: v, is_store, phy_reg, old_phy, comp.
- Allocation, evaluated at the clock edge:
  - Only when disp_ready = 1. When disp_ready = 0, disp_valid_* are ignored, nothing is written, and tail is unchanged.
  - Valid slots pack: slot 1 takes tail; slot 2 takes tail+1 if slot 1 is valid, else tail.
  - disp_tag_1 = tail. disp_tag_2 = tail + disp_valid_1.
  - tail advances by the number of valid slots, modulo 16 (15 -> 0 wraps).
  - New entry: v = 1, comp = 0, is_store = (op == 7'b0100011).
- disp_ready uses count before the edge. Same-cycle retires do not free allocation space.
- Completion, at the edge:
  - For each cmp_valid_k, set comp at cmp_tag_k if that entry's v = 1.
  - A completion to an invalid entry is ignored.
  - Duplicate tags across ports are harmless.
  - Completion to an entry allocated in the same edge is ignored; the FU cannot hold that tag yet.
- Retire, at the edge, using pre-edge state:
  - R1: entry[head] has v && comp.
  - R2: R1 and entry[head+1] has v && comp.
  - Retired entries clear v and comp. head advances by R1+R2, modulo 16.
  - rt_valid_1 <= R1; rt_flag_1 <= R1 && !is_store; fp_i_1 <= old_phy of entry[head], else 0. Slot 2 is the same for head+1.
  - Latency: completion at edge N -> retire registered at edge N+1, so rt_* is visible during cycle N+1. Never the same edge.
- count_next = count + allocated - retired. Allocate and retire may occur in the same edge.
- Full (count = 16): disp_ready = 0; retire continues.
- count = 15: disp_ready = 0, even for a single request.
- Empty: no retire.
- head == tail is disambiguated only by count.
- rt_* outputs are single-cycle pulses, cleared on the next edge unless re-asserted.

Decomposition:
- Package p:
  - rob_row typedef: add the comp and is_store fields; drop result/old_result.
  - OP_STORE = 7'b0100011.
  - ROB_DEPTH.
- No sub-module. The entry array, head/tail/count, and retire logic live in one module of about 250 lines.

Test Plan:
- Reset mid-run with count = 5 -> next cycle rob_count = 0, rob_empty = 1, disp_ready = 1, rt_valid_* = 0, disp_tag_1 = 0.
- Dispatch pairs (rob_p 32/33, o_rob_p 1/2) for 8 cycles -> tags 0..15 assigned in order. After 7 pairs, rob_count = 14 and disp_ready = 1. After the 8th pair, rob_count = 16 and disp_ready = 0. A 9th request leaves the count at 16.
- Complete tag 1 only, then tag 0 -> no retire after tag 1. The edge after tag 0 completes gives rt_valid_1 = rt_valid_2 = 1, fp_i_1 = 1, fp_i_2 = 2.
- Store in slot 1 (rob_op_1 = 7'b0100011), completed -> rt_valid_1 = 1, rt_flag_1 = 0.
- Wrap-around:
  - Fill 16, complete and retire all, then dispatch 2 more -> tags 0 and 1 reused, head wraps 15 -> 0.
  - Repeat the fill with a completion to a stale tag (v = 0) -> that completion is ignored.
- Same edge: count = 16, 2 retires plus dispatch request -> dispatch refused (disp_ready = 0), count becomes 14. Next cycle dispatch is accepted.
